alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, registered successor to the 8-bit combinational ALU, with width set by WIDTH. Valid/ready handshakes on both the operand side and the result side. Single-cycle ops have 1-cycle latency and can run back-to-back at full throughput. MUL/DIV/REM are multi-cycle ops built from an iterative shift-add / restoring-divide engine. Sits between the operand-issue logic and the writeback stage.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 4..32)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and sel are valid
in_ready  output  1  block can accept an operation this cycle
x  input  WIDTH  operand A
y  input  WIDTH  operand B
sel  input  4  opcode, encoded as in Behaviour
out_valid  output  1  result and flags are valid
out_ready  input  1  downstream accepts the result
out  output  WIDTH  result
zero  output  1  out == 0
carry  output  1  carry/borrow/shifted-out bit
overflow  output  1  signed overflow, MUL truncation, or divide-by-zero
negative  output  1  out[WIDTH-1]

Behaviour:
- Reset: clk and rst_n are the single clock and the asynchronous active-low reset. Reset clears all state immediately (no wait for a clock edge), including a MUL/DIV in flight. State returns to IDLE; out_valid=0, out=0, all flags=0, in_ready=1 once rst_n deasserts.
- Opcodes (sel):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 NOT x
  - 7 SHL1, 8 SHR1 (logical), 9 SAR1, 10 INC x, 11 DEC x
  - 12 MUL (unsigned), 13 DIV (unsigned quotient), 14 REM (unsigned remainder)
  - 15 CMP (SUB flags; out=x)
- Arithmetic and flag rules:
  - ADD/INC: carry = bit WIDTH of the sum.
  - SUB/DEC/CMP: carry = borrow, i.e. x<y unsigned.
  - overflow for ADD/SUB/INC/DEC/CMP = two's-complement signed overflow. INC/DEC treat y as 1.
  - Logic ops (AND/OR/XOR/NOR/NOT): carry=0, overflow=0.
  - Shifts: carry = bit shifted out; overflow=0.
  - MUL: out = low WIDTH bits of the product; carry = overflow = (high half != 0).
  - DIV/REM with y=0: quotient = all ones, remainder = x, overflow=1, carry=0.
  - DIV/REM with y!=0: carry=0, overflow=0.
  - zero and negative are always derived from the registered out.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Result transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready: out and all flags are held stable.
- FSM:
  - IDLE: on accepting a single-cycle op -> DONE; on accepting MUL/DIV/REM -> BUSY.
  - BUSY: iteration counter runs WIDTH cycles, then -> DONE; in_ready=0 throughout.
  - DONE: out_valid=1. On transfer: if a new op is accepted in the same cycle, go to DONE (single-cycle op) or BUSY (multi-cycle op); otherwise go to IDLE.
- Latency:
  - Single-cycle ops: out_valid in the cycle after accept.
  - MUL/DIV/REM: out_valid WIDTH+1 cycles after accept.
- Operands and sel are captured at accept; later input changes have no effect.

Optional Feature:
ALU_MULDIV_EN
- Defined: opcodes 12-14 use the iterative engine as specified above.
- Undefined: the engine is not instantiated and opcodes 12-14 complete as single-cycle ops with out=0, zero=1, carry=0, overflow=1. The BUSY state is unreachable.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_CMP), FSM state encoding (IDLE/BUSY/DONE), and a flag-bundle struct {zero, carry, overflow, negative}.
- Sub-module alu_muldiv_seq: iterative shift-add multiplier and restoring divider.
  - Inputs: start, op, a, b.
  - Outputs: done, result, div0, hi_nonzero.
  - Instantiated only under ALU_MULDIV_EN.

Test Plan:
1. WIDTH=8, x=25, y=15, sel=0..11 back-to-back with out_ready=1 -> one result per cycle. ADD gives 40 (c=0, v=0); SUB gives 10; AND gives 9; XOR gives 22; SHL1 gives 50; DEC gives 24.
2. x=128, y=128, ADD -> out=0, zero=1, carry=1, overflow=1. Then SUB x=15, y=25 -> out=246, carry=1, negative=1, overflow=0.
3. MUL x=25, y=15 -> out_valid exactly 9 cycles after accept, out=119, carry=1, overflow=1. Verify in_ready=0 while BUSY.
4. DIV x=25, y=0 -> out=255, overflow=1. DIV x=25, y=4 -> out=6. REM x=25, y=4 -> out=1.
5. Hold out_ready=0 for 3 cycles after an ADD result -> out and flags are stable and in_ready=0. Raise out_ready together with a new in_valid -> transfer and new accept happen in the same cycle.
6. Assert rst_n=0 mid-MUL (cycle 4) -> out_valid=0 and flags=0 immediately, without waiting for a clock edge. After release, in_ready=1 and a fresh ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag bundle for the sequential ALU.
// The multiply/divide engine is compiled in only when ALU_MULDIV_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_SAR = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_DEC = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;
    localparam logic [3:0] OP_DIV = 4'd13;
    localparam logic [3:0] OP_REM = 4'd14;
    localparam logic [3:0] OP_CMP = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic negative;
    } flags_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// The first iteration runs in the start cycle so the result is ready WIDTH cycles later.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div0,
    output logic             hi_nonzero
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi, lo, b_r;
    logic [3:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             busy;

    logic [WIDTH-1:0] cur_hi, cur_lo, cur_b;
    logic             cur_mul;
    logic [WIDTH:0]   sum, rem_try;
    logic             ge;
    logic [WIDTH-1:0] nx_hi, nx_lo;

    // In the start cycle the step works on the incoming operands directly
    always_comb begin
        cur_hi  = start ? '0 : hi;
        cur_lo  = start ? a  : lo;
        cur_b   = start ? b  : b_r;
        cur_mul = start ? (op == OP_MUL) : (op_r == OP_MUL);
        sum     = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
        rem_try = {cur_hi, cur_lo[WIDTH-1]};
        ge      = rem_try >= {1'b0, cur_b};
        if (cur_mul) begin
            nx_hi = sum[WIDTH:1];
            nx_lo = {sum[0], cur_lo[WIDTH-1:1]};
        end else begin
            nx_hi = ge ? WIDTH'(rem_try - {1'b0, cur_b})
                       : rem_try[WIDTH-1:0];
            nx_lo = {cur_lo[WIDTH-2:0], ge};
        end
    end

    assign done = busy && (cnt == CW'(WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            b_r  <= '0;
            op_r <= OP_MUL;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            hi   <= nx_hi;
            lo   <= nx_lo;
            b_r  <= b;
            op_r <= op;
            cnt  <= CW'(1);
            busy <= 1'b1;
        end else if (busy && !done) begin
            hi  <= nx_hi;
            lo  <= nx_lo;
            cnt <= cnt + CW'(1);
        end else if (done) begin
            busy <= 1'b0;
        end
    end

    assign result     = (op_r == OP_REM) ? hi : lo;
    assign div0       = (b_r == '0);
    assign hi_nonzero = |hi;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; define ALU_MULDIV_EN
// to build the iterative MUL/DIV/REM engine, otherwise those ops report overflow.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    localparam int MSB = WIDTH - 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] out_r;
    flags_t           flg_r;
    logic             accept;
    logic             md_sel, md_done, md_div0, md_hi_nz;
    logic [WIDTH-1:0] md_res;
    flags_t           md_flg;

    assign accept = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
    logic md_mul;

    assign md_sel = is_muldiv(sel);

    alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (accept && md_sel),
        .op         (sel),
        .a          (x),
        .b          (y),
        .done       (md_done),
        .result     (md_res),
        .div0       (md_div0),
        .hi_nonzero (md_hi_nz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            md_mul <= 1'b0;
        else if (accept)
            md_mul <= (sel == OP_MUL);
    end

    always_comb begin
        md_flg.zero     = (md_res == '0);
        md_flg.carry    = md_mul && md_hi_nz;
        md_flg.overflow = md_mul ? md_hi_nz : md_div0;
        md_flg.negative = md_res[MSB];
    end
`else
    assign md_sel   = 1'b0;
    assign md_done  = 1'b0;
    assign md_div0  = 1'b0;
    assign md_hi_nz = 1'b0;
    assign md_res   = '0;
    assign md_flg   = '0;
`endif

    logic [WIDTH-1:0] opb, res;
    logic [WIDTH:0]   add_s, sub_d;
    logic             add_v, sub_v, c, v;

    // INC/DEC reuse the adder with the second operand forced to one
    always_comb begin
        opb   = ((sel == OP_INC) || (sel == OP_DEC))
              ? WIDTH'(1) : y;
        add_s = {1'b0, x} + {1'b0, opb};
        sub_d = {1'b0, x} - {1'b0, opb};
        add_v = (x[MSB] == opb[MSB]) && (add_s[MSB] != x[MSB]);
        sub_v = (x[MSB] != opb[MSB]) && (sub_d[MSB] != x[MSB]);
        res   = '0;
        c     = 1'b0;
        v     = 1'b0;
        unique case (sel)
            OP_ADD, OP_INC: begin
                res = add_s[MSB:0]; c = add_s[WIDTH]; v = add_v;
            end
            OP_SUB, OP_DEC: begin
                res = sub_d[MSB:0]; c = sub_d[WIDTH]; v = sub_v;
            end
            OP_CMP: begin
                res = x; c = sub_d[WIDTH]; v = sub_v;
            end
            OP_AND: res = x & y;
            OP_OR:  res = x | y;
            OP_XOR: res = x ^ y;
            OP_NOR: res = ~(x | y);
            OP_NOT: res = ~x;
            OP_SHL: begin res = {x[MSB-1:0], 1'b0};  c = x[MSB]; end
            OP_SHR: begin res = {1'b0, x[MSB:1]};    c = x[0];   end
            OP_SAR: begin res = {x[MSB], x[MSB:1]};  c = x[0];   end
            default: v = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = md_sel ? BUSY : DONE;
            BUSY: if (md_done) state_nx = DONE;
            DONE: if (out_ready)
                      state_nx = !accept ? IDLE : (md_sel ? BUSY : DONE);
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= '0;
            flg_r <= '0;
        end else if (accept && !md_sel) begin
            out_r          <= res;
            flg_r.zero     <= (res == '0);
            flg_r.carry    <= c;
            flg_r.overflow <= v;
            flg_r.negative <= res[MSB];
        end else if ((state == BUSY) && md_done) begin
            out_r <= md_res;
            flg_r <= md_flg;
        end
    end

    assign out      = out_r;
    assign zero     = flg_r.zero;
    assign carry    = flg_r.carry;
    assign overflow = flg_r.overflow;
    assign negative = flg_r.negative;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8; expectations for opcodes 12-14
// follow whichever build (ALU_MULDIV_EN defined or not) is compiled.
module tb_alu_seq;

    localparam int W = 8;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, in_valid, out_ready;
    logic [W-1:0] x, y, out;
    logic [3:0]   sel;
    logic         in_ready, out_valid, zero, carry, overflow, negative;
    logic [3:0]   fl;
    int           total = 0;
    int           bad = 0;
    int           lat;

    logic [7:0] exp_out [12] = '{8'd40, 8'd10, 8'd9, 8'd31, 8'd22, 8'd224,
                                 8'd230, 8'd50, 8'd12, 8'd12, 8'd26, 8'd24};
    logic [3:0] exp_fl  [12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                 4'b0000, 4'b0001, 4'b0001, 4'b0000,
                                 4'b0100, 4'b0100, 4'b0000, 4'b0000};

    assign fl = {zero, carry, overflow, negative};

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns with the result visible (or timeout)
    task automatic run_op(input logic [3:0] s, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        sel = s; x = a; y = b; in_valid = 1'b1;
        chk("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; x = '1; y = '1; sel = 4'd0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk("busy_ready", in_ready, 0);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; sel = 4'd0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_flags", fl, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", in_ready, 1);

        // back-to-back single-cycle ops
        for (int i = 0; i < 12; i++) begin
            sel = 4'(i); x = 8'd25; y = 8'd15; in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("b2b_valid_%0d", i), out_valid, 1);
            chk($sformatf("b2b_out_%0d", i), out, exp_out[i]);
            chk($sformatf("b2b_fl_%0d", i), fl, exp_fl[i]);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle", out_valid, 0);

        run_op(4'd0, 8'd128, 8'd128);
        chk("add_wrap_out", out, 0);
        chk("add_wrap_fl", fl, 4'b1110);
        run_op(4'd1, 8'd15, 8'd25);
        chk("sub_neg_out", out, 246);
        chk("sub_neg_fl", fl, 4'b0101);

        run_op(4'd12, 8'd25, 8'd15);
        chk("mul_lat", lat, MD ? W + 1 : 1);
        chk("mul_out", out, MD ? 119 : 0);
        chk("mul_fl", fl, MD ? 4'b0110 : 4'b1010);

        run_op(4'd13, 8'd25, 8'd0);
        chk("div0_out", out, MD ? 255 : 0);
        chk("div0_fl", fl, MD ? 4'b0011 : 4'b1010);
        run_op(4'd13, 8'd25, 8'd4);
        chk("div_out", out, MD ? 6 : 0);
        chk("div_fl", fl, MD ? 4'b0000 : 4'b1010);
        run_op(4'd14, 8'd25, 8'd4);
        chk("rem_out", out, MD ? 1 : 0);
        chk("rem_fl", fl, MD ? 4'b0000 : 4'b1010);

        // backpressure, then transfer + accept in one cycle
        @(negedge clk);
        out_ready = 1'b0;
        sel = 4'd0; x = 8'd3; y = 8'd4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; x = 8'd99;
        chk("hold_first", out, 7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold_out_%0d", i), out, 7);
            chk($sformatf("hold_fl_%0d", i), fl, 4'b0000);
            chk($sformatf("hold_ready_%0d", i), in_ready, 0);
            chk($sformatf("hold_valid_%0d", i), out_valid, 1);
        end
        out_ready = 1'b1;
        sel = 4'd3; x = 8'd5; y = 8'd10; in_valid = 1'b1;
        #1;
        chk("overlap_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("overlap_valid", out_valid, 1);
        chk("overlap_out", out, 15);
        @(negedge clk);
        chk("overlap_idle", out_valid, 0);

        // asynchronous reset while a multiply is in flight
        sel = 4'd12; x = 8'd25; y = 8'd15; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_out", out, 0);
        chk("async_fl", fl, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_ready", in_ready, 1);
        @(negedge clk);
        chk("post_rst_valid", out_valid, 0);
        run_op(4'd0, 8'd1, 8'd1);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_out", out, 2);
        chk("post_rst_fl", fl, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
